// File: rtl/sisc_pkg.sv
// Shared SISC encodings and default bus widths.
package sisc_pkg;

  localparam int SISC_AW = 16;
  localparam int SISC_DW = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb.sv
// Two-requester arbiter for the single-port SISC memory (instruction fetch vs. load/store).
// Latency: mem_en one cycle after req, held WAIT+1 cycles, then a one-cycle ack; WAIT+3 cycles per access.
// Backpressure: requesters hold req until their ack; busy stalls ctrl; no grant during ACK.
module mem_arb
  import sisc_pkg::*;
#(
  parameter int AW   = SISC_AW,
  parameter int DW   = SISC_DW,
  parameter int WAIT = 1
) (
  input  logic          clk,
  input  logic          rst_f,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic [3:0] WAIT_CNT = 4'(WAIT);

  arb_state_t state, state_nxt;
  owner_t     owner, last_owner, winner;
  logic [3:0] cnt;
  logic       req_any, cnt_done;

  assign req_any  = if_req | d_req;
  assign cnt_done = (cnt == 4'd0);
  assign busy     = (state != IDLE);

  // A tie goes to whichever port did not win the previous access.
  always_comb begin
    winner = OWN_IF;
    if (if_req && d_req) begin
      if (last_owner == OWN_IF) winner = OWN_D;
      else                      winner = OWN_IF;
    end else if (d_req) begin
      winner = OWN_D;
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_any)  state_nxt = BUSY;
      BUSY:    if (cnt_done) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      owner      <= OWN_IF;
      last_owner <= OWN_D;
      cnt        <= 4'd0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_ack     <= 1'b0;
      d_ack      <= 1'b0;
      if_rdata   <= '0;
      d_rdata    <= '0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            owner      <= winner;
            last_owner <= winner;
            mem_en     <= 1'b1;
            cnt        <= WAIT_CNT;
            if (winner == OWN_D) begin
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              mem_we    <= d_we;
            end else begin
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              mem_we    <= 1'b0;
            end
          end
        end
        BUSY: begin
          if (cnt_done) begin
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (owner == OWN_IF) begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end else begin
              d_ack <= 1'b1;
              if (!mem_we) d_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Three mem_arb instances (WAIT = 1, 0, 3) driven by directed and random requesters,
// checked every cycle against a transaction-timing model.
module tb_mem_arb;

  localparam int NL = 3;
  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_f;

  logic [NL-1:0]         if_req, d_req, d_we;
  logic [NL-1:0][AW-1:0] if_addr, d_addr;
  logic [NL-1:0][DW-1:0] d_wdata, mem_rdata;
  logic [NL-1:0]         if_ack, d_ack, mem_en, mem_we, busy;
  logic [NL-1:0][AW-1:0] mem_addr;
  logic [NL-1:0][DW-1:0] if_rdata, d_rdata, mem_wdata;

  logic [DW-1:0] env_mem [NL][256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NL; g++) begin : g_lane
    mem_arb #(.AW(AW), .DW(DW), .WAIT(g == 0 ? 1 : (g == 1 ? 0 : 3))) u_dut (
      .clk       (clk),
      .rst_f     (rst_f),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_ack    (if_ack[g]),
      .if_rdata  (if_rdata[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_ack     (d_ack[g]),
      .d_rdata   (d_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g])
    );
    assign mem_rdata[g] = env_mem[g][mem_addr[g][7:0]];
  end

  // Model: one in-flight access per lane, timed from its grant edge.
  int            cyc;
  int            checks, errors;
  bit            m_act  [NL];
  int            m_g    [NL];
  bit            m_own  [NL];   // 0 = fetch, 1 = data
  bit            m_last [NL];
  bit            m_we   [NL];
  logic [AW-1:0] m_addr [NL];
  logic [DW-1:0] m_wdata[NL];
  logic [DW-1:0] m_ifr  [NL];
  logic [DW-1:0] m_dr   [NL];
  logic [DW-1:0] m_mem  [NL][256];

  function automatic int wait_of(int l);
    return (l == 0) ? 1 : ((l == 1) ? 0 : 3);
  endfunction

  function automatic void chk_l(int l, string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL lane%0d %s: got %h, expected %h (cycle %0d)", l, nm, a, e, cyc);
    end
  endfunction

  function automatic void model_reset();
    for (int l = 0; l < NL; l++) begin
      m_act[l]   = 1'b0;
      m_last[l]  = 1'b1;
      m_own[l]   = 1'b0;
      m_we[l]    = 1'b0;
      m_addr[l]  = '0;
      m_wdata[l] = '0;
      m_ifr[l]   = '0;
      m_dr[l]    = '0;
    end
  endfunction

  // Called at each rising edge with the inputs that were stable before it.
  function automatic void model_edge();
    for (int l = 0; l < NL; l++) begin
      int w, d;
      w = wait_of(l);
      if (m_act[l]) begin
        d = cyc - m_g[l];
        if (d == w + 1) begin
          if (!m_own[l])    m_ifr[l] = m_mem[l][m_addr[l][7:0]];
          else if (m_we[l]) m_mem[l][m_addr[l][7:0]] = m_wdata[l];
          else              m_dr[l] = m_mem[l][m_addr[l][7:0]];
        end
        if (d == w + 2) m_act[l] = 1'b0;
      end else if (if_req[l] || d_req[l]) begin
        m_own[l]  = (if_req[l] && d_req[l]) ? !m_last[l] : d_req[l];
        m_last[l] = m_own[l];
        m_act[l]  = 1'b1;
        m_g[l]    = cyc;
        if (m_own[l]) begin
          m_addr[l] = d_addr[l]; m_we[l] = d_we[l]; m_wdata[l] = d_wdata[l];
        end else begin
          m_addr[l] = if_addr[l]; m_we[l] = 1'b0; m_wdata[l] = '0;
        end
      end
    end
  endfunction

  function automatic bit m_ack(int l, bit port);
    return m_act[l] && ((cyc - m_g[l]) == wait_of(l) + 1) && (m_own[l] == port);
  endfunction

  function automatic void check_all();
    for (int l = 0; l < NL; l++) begin
      int   w, d;
      logic en_e, ack_e, busy_e;
      w = wait_of(l);
      en_e = 1'b0; ack_e = 1'b0; busy_e = 1'b0;
      if (m_act[l]) begin
        d      = cyc - m_g[l];
        en_e   = (d <= w);
        ack_e  = (d == w + 1);
        busy_e = 1'b1;
      end
      chk_l(l, "mem_en",    32'(mem_en[l]),   32'(en_e));
      chk_l(l, "mem_we",    32'(mem_we[l]),   32'(en_e & m_we[l]));
      chk_l(l, "mem_addr",  32'(mem_addr[l]), 32'(m_addr[l]));
      chk_l(l, "mem_wdata", mem_wdata[l],     m_wdata[l]);
      chk_l(l, "if_ack",    32'(if_ack[l]),   32'(ack_e & ~m_own[l]));
      chk_l(l, "d_ack",     32'(d_ack[l]),    32'(ack_e & m_own[l]));
      chk_l(l, "if_rdata",  if_rdata[l],      m_ifr[l]);
      chk_l(l, "d_rdata",   d_rdata[l],       m_dr[l]);
      chk_l(l, "busy",      32'(busy[l]),     32'(busy_e));
    end
  endfunction

  // Memory environment: stores land while mem_en && mem_we are high.
  function automatic void env_write();
    for (int l = 0; l < NL; l++)
      if (mem_en[l] && mem_we[l]) env_mem[l][mem_addr[l][7:0]] = mem_wdata[l];
  endfunction

  task automatic step();
    @(posedge clk);
    cyc++;
    if (!rst_f) model_reset();
    else        model_edge();
    @(negedge clk);
    check_all();
    env_write();
  endtask

  initial begin
    int ord[$];
    int when[$];
    int exp_ord[4];
    int both, en_cnt, busy_cnt, ack_at, ack_seen;

    exp_ord = '{0, 1, 0, 1};
    cyc = 0; checks = 0; errors = 0;
    if_req = '0; d_req = '0; d_we = '0;
    if_addr = '0; d_addr = '0; d_wdata = '0;
    for (int l = 0; l < NL; l++)
      for (int i = 0; i < 256; i++) begin
        env_mem[l][i] = {8'(l), 8'(i), 16'hC0DE ^ 16'(i * 37)};
        m_mem[l][i]   = env_mem[l][i];
      end
    env_mem[0][4] = 32'h1234_5678;
    m_mem[0][4]   = 32'h1234_5678;
    model_reset();

    rst_f = 1'b1;
    #1 rst_f = 1'b0;
    repeat (3) step();
    rst_f = 1'b1;
    step();

    // Single fetch, WAIT=1
    if_req[0] = 1'b1; if_addr[0] = 16'h0004;
    step();
    chk_l(0, "fetch mem_en c1", 32'(mem_en[0]), 32'd1);
    chk_l(0, "fetch mem_addr", 32'(mem_addr[0]), 32'h0004);
    chk_l(0, "fetch mem_we", 32'(mem_we[0]), 32'd0);
    step();
    chk_l(0, "fetch mem_en c2", 32'(mem_en[0]), 32'd1);
    step();
    chk_l(0, "fetch if_ack", 32'(if_ack[0]), 32'd1);
    chk_l(0, "fetch if_rdata", if_rdata[0], 32'h1234_5678);
    chk_l(0, "fetch d_ack", 32'(d_ack[0]), 32'd0);
    chk_l(0, "fetch mem_en off", 32'(mem_en[0]), 32'd0);
    if_req[0] = 1'b0;
    step();
    chk_l(0, "fetch ack pulse", 32'(if_ack[0]), 32'd0);

    // Store then load, WAIT=0
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 16'h0010; d_wdata[1] = 32'hDEAD_BEEF;
    step();
    chk_l(1, "store mem_we", 32'(mem_we[1]), 32'd1);
    chk_l(1, "store mem_wdata", mem_wdata[1], 32'hDEAD_BEEF);
    step();
    chk_l(1, "store d_ack", 32'(d_ack[1]), 32'd1);
    chk_l(1, "store d_rdata", d_rdata[1], 32'd0);
    d_req[1] = 1'b0; d_we[1] = 1'b0;
    step();
    d_req[1] = 1'b1;
    step();
    step();
    chk_l(1, "load d_ack", 32'(d_ack[1]), 32'd1);
    chk_l(1, "load d_rdata", d_rdata[1], 32'hDEAD_BEEF);
    d_req[1] = 1'b0;
    step();

    // Address change while BUSY is ignored
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0010;
    step();
    chk_l(0, "hold mem_addr c1", 32'(mem_addr[0]), 32'h0010);
    d_addr[0] = 16'h0020;
    step();
    chk_l(0, "hold mem_addr c2", 32'(mem_addr[0]), 32'h0010);
    step();
    chk_l(0, "hold d_ack", 32'(d_ack[0]), 32'd1);
    d_req[0] = 1'b0;
    step();

    // Reset during the second BUSY cycle
    if_req[0] = 1'b1; if_addr[0] = 16'h0008;
    step();
    step();
    rst_f = 1'b0;
    #1;
    chk_l(0, "arst mem_en", 32'(mem_en[0]), 32'd0);
    chk_l(0, "arst mem_we", 32'(mem_we[0]), 32'd0);
    chk_l(0, "arst if_ack", 32'(if_ack[0]), 32'd0);
    chk_l(0, "arst d_ack", 32'(d_ack[0]), 32'd0);
    chk_l(0, "arst busy", 32'(busy[0]), 32'd0);
    model_reset();
    check_all();
    if_req[0] = 1'b0;
    step();
    step();
    rst_f = 1'b1;
    ack_seen = 0;
    repeat (6) begin
      step();
      if (if_ack[0] || d_ack[0]) ack_seen++;
    end
    chk_l(0, "arst no ack", 32'(ack_seen), 32'd0);

    // Tie fairness right after reset: IF first, then alternating
    both = 0;
    if_req[0] = 1'b1; if_addr[0] = 16'h0040;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 16'h0044;
    for (int k = 0; k < 40 && ord.size() < 4; k++) begin
      step();
      if (if_ack[0] && d_ack[0]) both++;
      if (if_ack[0])     begin ord.push_back(0); when.push_back(cyc); end
      else if (d_ack[0]) begin ord.push_back(1); when.push_back(cyc); end
    end
    if_req[0] = 1'b0; d_req[0] = 1'b0;
    chk_l(0, "tie ack count", 32'(ord.size()), 32'd4);
    chk_l(0, "tie both acks", 32'(both), 32'd0);
    for (int i = 0; i < ord.size() && i < 4; i++) begin
      chk_l(0, $sformatf("tie order %0d", i), 32'(ord[i]), 32'(exp_ord[i]));
      if (i > 0) chk_l(0, $sformatf("tie spacing %0d", i), 32'(when[i] - when[i-1]), 32'd4);
    end
    step();

    // WAIT=3 single load
    en_cnt = 0; busy_cnt = 0; ack_at = 0;
    d_req[2] = 1'b1; d_we[2] = 1'b0; d_addr[2] = 16'h0030;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (mem_en[2]) en_cnt++;
      if (busy[2])   busy_cnt++;
      if (d_ack[2]) begin ack_at = k; d_req[2] = 1'b0; end
    end
    chk_l(2, "w3 mem_en cycles", 32'(en_cnt), 32'd4);
    chk_l(2, "w3 busy cycles", 32'(busy_cnt), 32'd5);
    chk_l(2, "w3 ack cycle", 32'(ack_at), 32'd5);

    // Random traffic on all lanes
    repeat (3000) begin
      for (int l = 0; l < NL; l++) begin
        if (m_ack(l, 1'b0)) begin
          if_req[l] = 1'($urandom_range(0, 1)); if_addr[l] = 16'($urandom);
        end else if (if_req[l]) begin
          if ($urandom_range(0, 9) == 0)  if_addr[l] = 16'($urandom);
          if ($urandom_range(0, 29) == 0) if_req[l] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          if_req[l] = 1'b1; if_addr[l] = 16'($urandom);
        end
        if (m_ack(l, 1'b1) || (!d_req[l] && $urandom_range(0, 2) == 0)) begin
          d_req[l] = 1'($urandom_range(0, 1)); d_we[l] = 1'($urandom_range(0, 1));
          d_addr[l] = 16'($urandom); d_wdata[l] = $urandom;
        end else if (d_req[l]) begin
          if ($urandom_range(0, 9) == 0)  begin d_addr[l] = 16'($urandom); d_wdata[l] = $urandom; end
          if ($urandom_range(0, 29) == 0) d_req[l] = 1'b0;
        end
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
Name: mem_arb

Overview:
- Arbitrates a single-port SISC memory between two requesters: instruction fetch (IF port, driven around ctrl's fetch state) and data access (D port, LOD/STR in ctrl's mem state).
- Latches the winner's address, write data and write enable, holds the memory enable for a programmable number of wait cycles, then returns read data with a one-cycle ack pulse.
- Sits between ctrl/datapath and the memory model; gives ctrl a busy indication so it can stall.

Parameters:
- AW, 16, address width.
- DW, 32, data width.
- WAIT, 1, extra memory wait cycles per access (0..15); BUSY lasts WAIT+1 cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rst_f  input  1  asynchronous, active-low reset.
- if_req  input  1  fetch request; held high until if_ack.
- if_addr  input  AW  fetch address (PC).
- if_ack  output  1  one-cycle pulse; if_rdata is valid in the same cycle.
- if_rdata  output  DW  registered fetch data.
- d_req  input  1  data request; held high until d_ack.
- d_we  input  1  1 = store, 0 = load.
- d_addr  input  AW  data address.
- d_wdata  input  DW  store data.
- d_ack  output  1  one-cycle pulse.
- d_rdata  output  DW  registered load data; unchanged by stores.
- mem_en  output  1  memory enable, registered.
- mem_we  output  1  memory write enable, registered.
- mem_addr  output  AW  registered address.
- mem_wdata  output  DW  registered write data.
- mem_rdata  input  DW  memory read data; valid while mem_en is high on the last BUSY cycle.
- busy  output  1  high in BUSY and ACK.

Behaviour:
- Reset (rst_f low, asynchronous):
  - State = IDLE, cnt = 0, last_owner = D.
  - All outputs 0: mem_en, mem_we, mem_addr, mem_wdata, if_ack, d_ack, if_rdata, d_rdata, busy.
  - Reset mid-access aborts it; no ack is issued.
- States:
  - IDLE: requests sampled only here.
    - Neither requesting: stay in IDLE.
    - Exactly one requesting: grant it.
    - Both requesting: grant the one that is not last_owner (alternating fairness). After reset the fetch port wins the first tie.
    - On grant, at the clock edge: owner <= winner, last_owner <= winner, mem_addr/mem_wdata/mem_we <= winner's inputs (fetch: mem_we = 0, mem_wdata = 0), mem_en <= 1, cnt <= WAIT, state <= BUSY.
  - BUSY: mem_en = 1; mem_addr/mem_we/mem_wdata stay stable, and requester input changes are ignored.
    - cnt != 0: cnt decrements.
    - cnt == 0: at the edge, the owner's rdata register <= mem_rdata (loads and fetches only), that port's ack <= 1, mem_en <= 0, mem_we <= 0, state <= ACK.
  - ACK: exactly one ack high for one cycle; next state is IDLE; ack clears.
    - No grant is made in ACK, which gives a guaranteed turnaround cycle.
- Latency: request first seen high in IDLE cycle N; mem_en high in cycles N+1 .. N+1+WAIT; ack high in cycle N+2+WAIT. Back-to-back accesses take WAIT+3 cycles each.
- Requester rule: drop req (or present the next request) on the edge that ends the ACK cycle. A req still high in the following IDLE cycle is treated as a new request.
- A request withdrawn during BUSY does not cancel the access; the ack is still pulsed.
- rdata registers hold their value until the next completed read by the same port.
- A store on the D port writes mem_wdata for all WAIT+1 BUSY cycles; d_rdata is unchanged.
- ctrl HLT handling is outside this block; an in-flight access always completes.

Decomposition:
- Shared package sisc_pkg:
  - State encodings: IDLE = 2'd0, BUSY = 2'd1, ACK = 2'd2.
  - Owner encodings: OWN_IF = 1'b0, OWN_D = 1'b1.
  - Default AW/DW constants.
- Single module; the wait counter stays inline. No sub-module is warranted.

Test Plan:
- Reset then single fetch: after release, if_req=1, if_addr=16'h0004, mem returns 32'h1234_5678 (WAIT=1) -> mem_en high 2 cycles with mem_addr=0004, mem_we=0; if_ack one pulse with if_rdata=12345678 in cycle N+3; d_ack stays 0.
- Store then load (WAIT=0): d_req, d_we=1, d_addr=0010, d_wdata=DEADBEEF -> mem_we=1 for 1 cycle, d_ack at N+2, d_rdata unchanged. Then a load of 0010 -> d_rdata=DEADBEEF.
- Tie fairness: if_req and d_req held continuously, 4 accesses -> grant order IF, D, IF, D; each ack separated by WAIT+3 cycles; never both acks in one cycle.
- Request change during BUSY: d_addr changes 0010 -> 0020 mid-BUSY -> mem_addr stays 0010 for the whole access.
- Reset mid-access: rst_f low during the second BUSY cycle -> mem_en, mem_we and both acks 0 immediately (asynchronously); after release the state is IDLE and no ack appears for the aborted access.
- WAIT=3 parameter sweep: single load -> mem_en high exactly 4 cycles, ack on the 5th cycle after grant, busy high for 5 cycles.
